// File: rtl/race_controller_if.sv
// Game-flow bundle between the menu/keyboard front end and the race sequencer.
// Master drives the control pulses; slave returns registered race status.
interface race_controller_if #(
  parameter int N_PLAYERS = 2,
  parameter int N_LIGHTS  = 3,
  parameter int POS_W     = 11,
  parameter int TIME_W    = 32,
  parameter int WIN_W     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
);
  logic                       start_game;
  logic                       abort;
  logic [N_PLAYERS-1:0]       accel_key;
  logic [1:0]                 state;
  logic [N_LIGHTS-1:0]        lights;
  logic                       go;
  logic [N_PLAYERS*POS_W-1:0] position;
  logic [N_PLAYERS-1:0]       false_start;
  logic [N_PLAYERS-1:0]       finished;
  logic [WIN_W-1:0]           winner;
  logic                       winner_valid;
  logic [TIME_W-1:0]          race_ticks;

  modport master (
    output start_game, abort, accel_key,
    input  state, lights, go, position, false_start, finished, winner, winner_valid, race_ticks
  );

  modport slave (
    input  start_game, abort, accel_key,
    output state, lights, go, position, false_start, finished, winner, winner_valid, race_ticks
  );
endinterface

// File: rtl/race_controller.sv
// Drag-race sequencer: countdown lights, lane positions, false starts, winner and race timer.
// Latency 1 cycle from any input pulse to outputs; no backpressure, every pulse is consumed.
module race_controller #(
  parameter int N_PLAYERS       = 2,
  parameter int N_LIGHTS        = 3,
  parameter int TICKS_PER_LIGHT = 65000000,
  parameter int POS_W           = 11,
  parameter int TRACK_LEN       = 1000,
  parameter int STEP            = 4,
  parameter int TIME_W          = 32
) (
  input  logic            clk,
  input  logic            rst,
  race_controller_if.slave bus
);
  localparam int WIN_W  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int TICK_W = $clog2(TICKS_PER_LIGHT);

  typedef enum logic [1:0] {IDLE = 2'd0, COUNTDOWN = 2'd1, RACE = 2'd2, FINISH = 2'd3} state_t;

  state_t                     state_q;
  logic [TICK_W-1:0]          tick;
  logic [N_LIGHTS-1:0]        lights_q;
  logic                       go_q;
  logic [N_PLAYERS*POS_W-1:0] position_q;
  logic [N_PLAYERS-1:0]       false_start_q;
  logic [N_PLAYERS-1:0]       finished_q;
  logic [WIN_W-1:0]           winner_q;
  logic                       winner_valid_q;
  logic [TIME_W-1:0]          race_ticks_q;

  logic [N_PLAYERS*POS_W-1:0] pos_nxt;
  logic [N_PLAYERS-1:0]       fin_nxt;
  logic [N_PLAYERS-1:0]       fin_new;
  logic [WIN_W-1:0]           first_idx;
  logic [POS_W:0]             sum [N_PLAYERS];
  logic                       hard_clear;
  logic                       restart;

  // Lane update used only in RACE; false-started or finished lanes are frozen.
  always_comb begin
    pos_nxt   = position_q;
    fin_nxt   = finished_q;
    first_idx = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      sum[i] = {1'b0, position_q[i*POS_W +: POS_W]} + (POS_W+1)'(STEP);
      if (bus.accel_key[i] && !false_start_q[i] && !finished_q[i]) begin
        if (sum[i] >= (POS_W+1)'(TRACK_LEN)) begin
          pos_nxt[i*POS_W +: POS_W] = POS_W'(TRACK_LEN);
          fin_nxt[i]                = 1'b1;
        end else begin
          pos_nxt[i*POS_W +: POS_W] = sum[i][POS_W-1:0];
        end
      end
    end
    fin_new = fin_nxt & ~finished_q;
    // Descending scan so the lowest simultaneous finisher wins.
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (fin_new[i]) first_idx = WIN_W'(i);
    end
  end

  assign hard_clear = rst || bus.abort;
  assign restart    = bus.start_game && (state_q == IDLE || state_q == FINISH);

  always_ff @(posedge clk) begin
    if (hard_clear || restart) begin
      state_q        <= hard_clear ? IDLE : COUNTDOWN;
      tick           <= '0;
      lights_q       <= '0;
      go_q           <= 1'b0;
      position_q     <= '0;
      false_start_q  <= '0;
      finished_q     <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      race_ticks_q   <= '0;
    end else begin
      case (state_q)
        COUNTDOWN: begin
          false_start_q <= false_start_q | bus.accel_key;
          if (tick == TICK_W'(TICKS_PER_LIGHT - 1)) begin
            tick <= '0;
            if (!lights_q[N_LIGHTS-1]) begin
              lights_q <= (lights_q << 1) | N_LIGHTS'(1);
            end else begin
              lights_q <= '0;
              go_q     <= 1'b1;
              state_q  <= RACE;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        RACE: begin
          position_q <= pos_nxt;
          finished_q <= fin_nxt;
          if (|fin_new && !winner_valid_q) begin
            winner_q       <= first_idx;
            winner_valid_q <= 1'b1;
          end
          // Timer runs until the first finish is registered.
          if (!(|finished_q) && race_ticks_q != '1) race_ticks_q <= race_ticks_q + 1'b1;
          if (&(fin_nxt | false_start_q)) begin
            go_q    <= 1'b0;
            state_q <= FINISH;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.lights       = lights_q;
  assign bus.go           = go_q;
  assign bus.position     = position_q;
  assign bus.false_start  = false_start_q;
  assign bus.finished     = finished_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.race_ticks   = race_ticks_q;
endmodule

// File: tb/tb_race_controller.sv
// Scoreboard bench for race_controller: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_race_controller;
  localparam int NP = 2, NL = 3, TPL = 4, PW = 11, TL = 12, ST = 4, TW = 32;
  localparam int S_STATE = 0, S_LIGHTS = 1, S_GO = 2, S_POS0 = 3, S_POS1 = 4,
                 S_FS = 5, S_FIN = 6, S_WIN = 7, S_WV = 8, S_TICKS = 9;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  string sig_name [10] = '{"state", "lights", "go", "pos0", "pos1",
                           "false_start", "finished", "winner", "winner_valid", "race_ticks"};

  race_controller_if #(.N_PLAYERS(NP), .N_LIGHTS(NL), .POS_W(PW), .TIME_W(TW)) bus ();

  race_controller #(
    .N_PLAYERS(NP), .N_LIGHTS(NL), .TICKS_PER_LIGHT(TPL), .POS_W(PW),
    .TRACK_LEN(TL), .STEP(ST), .TIME_W(TW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] dut_val(input int sel);
    case (sel)
      S_STATE:  return 64'(bus.state);
      S_LIGHTS: return 64'(bus.lights);
      S_GO:     return 64'(bus.go);
      S_POS0:   return 64'(bus.position[0 +: PW]);
      S_POS1:   return 64'(bus.position[PW +: PW]);
      S_FS:     return 64'(bus.false_start);
      S_FIN:    return 64'(bus.finished);
      S_WIN:    return 64'(bus.winner);
      S_WV:     return 64'(bus.winner_valid);
      default:  return 64'(bus.race_ticks);
    endcase
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e  = sb.pop_front();
      checks = checks + 1;
      if (mon_e.cyc != cyc || dut_val(mon_e.sel) !== mon_e.val) begin
        failures = failures + 1;
        $display("FAIL %s at cycle %0d (checked %0d): got %0h want %0h",
                 sig_name[mon_e.sel], mon_e.cyc, cyc, dut_val(mon_e.sel), mon_e.val);
      end
    end
  end

  task automatic push(input int c, input int sel, input logic [63:0] v);
    sb.push_back('{c, sel, v});
  endtask

  task automatic push_zero(input int c);
    for (int s = 0; s < 10; s++) push(c, s, 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic start_countdown(output int t0);
    t0 = cyc;
    push(t0 + 1, S_STATE, 64'd1);
    bus.start_game = 1'b1;
    step();
    bus.start_game = 1'b0;
  endtask

  task automatic push_full_countdown(input int t0);
    push(t0 + 1, S_LIGHTS, 64'd0);
    push(t0 + 4, S_LIGHTS, 64'd0);
    push(t0 + 5, S_LIGHTS, 64'd1);
    push(t0 + 9, S_LIGHTS, 64'd3);
    push(t0 + 13, S_LIGHTS, 64'd7);
    push(t0 + 16, S_STATE, 64'd1);
    push(t0 + 16, S_GO, 64'd0);
    push(t0 + 17, S_STATE, 64'd2);
    push(t0 + 17, S_GO, 64'd1);
    push(t0 + 17, S_LIGHTS, 64'd0);
    push(t0 + 17, S_TICKS, 64'd0);
  endtask

  initial begin
    int t0, r;
    rst = 1'b1;
    bus.start_game = 1'b0;
    bus.abort = 1'b0;
    bus.accel_key = '0;
    step();
    step();
    rst = 1'b0;
    push_zero(cyc);

    // Keys while idle are ignored.
    push(cyc + 1, S_STATE, 64'd0);
    push(cyc + 1, S_POS0, 64'd0);
    bus.accel_key = 2'b01;
    step();
    bus.accel_key = 2'b00;

    // Countdown timing and race entry.
    start_countdown(t0);
    push_full_countdown(t0);
    run_to(t0 + 17);
    r = cyc;

    // P0 finishes first, P1 follows; start_game in RACE is ignored.
    push(r + 1, S_POS0, 64'd4);
    push(r + 1, S_TICKS, 64'd1);
    push(r + 2, S_POS0, 64'd8);
    push(r + 2, S_WV, 64'd0);
    push(r + 3, S_POS0, 64'd12);
    push(r + 3, S_FIN, 64'd1);
    push(r + 3, S_WIN, 64'd0);
    push(r + 3, S_WV, 64'd1);
    push(r + 3, S_TICKS, 64'd3);
    push(r + 3, S_STATE, 64'd2);
    push(r + 4, S_STATE, 64'd2);
    push(r + 4, S_POS1, 64'd4);
    push(r + 5, S_TICKS, 64'd3);
    push(r + 6, S_POS1, 64'd12);
    push(r + 6, S_FIN, 64'd3);
    push(r + 6, S_STATE, 64'd3);
    push(r + 6, S_WIN, 64'd0);
    push(r + 6, S_WV, 64'd1);
    push(r + 6, S_TICKS, 64'd3);
    push(r + 8, S_STATE, 64'd3);
    push(r + 8, S_POS0, 64'd12);
    bus.accel_key = 2'b01;
    step(); step(); step();
    bus.accel_key = 2'b10;
    bus.start_game = 1'b1;
    step();
    bus.start_game = 1'b0;
    step(); step();
    bus.accel_key = 2'b00;
    run_to(r + 9);

    // Restart from FINISH; simultaneous finish resolves to lane 0.
    start_countdown(t0);
    push(t0 + 1, S_POS0, 64'd0);
    push(t0 + 1, S_FIN, 64'd0);
    push(t0 + 1, S_WV, 64'd0);
    push(t0 + 1, S_TICKS, 64'd0);
    run_to(t0 + 17);
    r = cyc;
    push(r + 2, S_POS0, 64'd8);
    push(r + 2, S_POS1, 64'd8);
    push(r + 2, S_FIN, 64'd0);
    push(r + 3, S_FIN, 64'd3);
    push(r + 3, S_WIN, 64'd0);
    push(r + 3, S_WV, 64'd1);
    push(r + 3, S_STATE, 64'd3);
    push(r + 3, S_POS1, 64'd12);
    bus.accel_key = 2'b11;
    step(); step(); step();
    bus.accel_key = 2'b00;
    run_to(r + 4);

    // P1 false start: P1 never moves, FINISH when P0 arrives.
    start_countdown(t0);
    run_to(t0 + 3);
    push(t0 + 4, S_FS, 64'd2);
    push(t0 + 17, S_STATE, 64'd2);
    bus.accel_key = 2'b10;
    step();
    bus.accel_key = 2'b00;
    run_to(t0 + 17);
    r = cyc;
    push(r + 1, S_POS0, 64'd4);
    push(r + 1, S_POS1, 64'd0);
    push(r + 2, S_STATE, 64'd2);
    push(r + 2, S_POS0, 64'd8);
    push(r + 2, S_FS, 64'd2);
    push(r + 3, S_POS0, 64'd12);
    push(r + 3, S_POS1, 64'd0);
    push(r + 3, S_FIN, 64'd1);
    push(r + 3, S_STATE, 64'd3);
    push(r + 3, S_WV, 64'd1);
    push(r + 3, S_WIN, 64'd0);
    bus.accel_key = 2'b11;
    step();
    bus.accel_key = 2'b01;
    step(); step();
    bus.accel_key = 2'b00;
    run_to(r + 4);

    // Both false start: straight through RACE to FINISH, no winner.
    start_countdown(t0);
    run_to(t0 + 2);
    push(t0 + 3, S_FS, 64'd3);
    bus.accel_key = 2'b11;
    step();
    bus.accel_key = 2'b00;
    run_to(t0 + 17);
    r = cyc;
    push(r, S_STATE, 64'd2);
    push(r, S_GO, 64'd1);
    push(r + 1, S_STATE, 64'd3);
    push(r + 1, S_WV, 64'd0);
    push(r + 1, S_FIN, 64'd0);
    run_to(r + 2);

    // Abort mid-RACE clears everything.
    start_countdown(t0);
    run_to(t0 + 17);
    r = cyc;
    push(r + 1, S_POS0, 64'd4);
    push_zero(r + 2);
    bus.accel_key = 2'b01;
    step();
    bus.accel_key = 2'b00;
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;

    // Restart after abort, then reset mid-COUNTDOWN.
    start_countdown(t0);
    push(t0 + 4, S_FS, 64'd2);
    push(t0 + 5, S_LIGHTS, 64'd1);
    push(t0 + 6, S_STATE, 64'd1);
    push_zero(t0 + 8);
    run_to(t0 + 3);
    bus.accel_key = 2'b10;
    step();
    bus.accel_key = 2'b00;
    run_to(t0 + 7);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Post-reset start repeats the original countdown timing.
    start_countdown(t0);
    push_full_countdown(t0);
    run_to(t0 + 20);

    if (sb.size() != 0) begin
      failures = failures + sb.size();
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
